counter_load_seq: RTL and testbench
===================================

// Module: counter_load_seq
// PURPOSE
//  Upstream sequencer for the 8-bit loadable counter. Buffers preload values in a small FIFO.
//  Issues them to the counter's load/load_in port one at a time, spaced by a programmable interval.
//  Drives the counter's output enable (en) while a sequence is running.
// PARAMETERS
//  DEPTH  4  FIFO entries (power of 2, >=2)
//  IW     8  width of interval input/timer
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        asynchronous reset, active-high
//  in_valid    in   1        preload value offered
//  in_data     in   8        preload value
//  in_ready    out  1        FIFO can accept (count < DEPTH)
//  start       in   1        begin/resume sequencing (level, sampled in IDLE)
//  stop        in   1        abort sequencing; priority over start
//  interval    in   IW       idle cycles between loads; sampled on LOAD->WAIT
//  load        out  1        to counter load; one-cycle pulse
//  load_in     out  8        to counter load_in; value of last pop
//  en          out  1        to counter en; 1 while state != IDLE
//  busy        out  1        state != IDLE (same as en)
//  fifo_count  out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  Reset (async, rst=1): FIFO empty, state IDLE, load=0, load_in=0, en=busy=0, in_ready=1.
//  Reset mid-operation drops all FIFO contents and any pending load.
//  FIFO push: in_valid & in_ready at posedge; in_ready = (count<DEPTH), independent of same-cycle pop.
//  Simultaneous push and pop: count unchanged; order strictly FIFO; pointers wrap mod DEPTH.
//  FSM states IDLE, LOAD, WAIT. All outputs registered/decoded from state, no comb path from inputs.
//   IDLE: stop=1 -> IDLE. start=1 & count>0 -> LOAD. else IDLE.
//   LOAD (exactly 1 cycle): load=1, load_in=head (popped this cycle, registered at state entry).
//     Next: stop=1 -> IDLE, else WAIT with timer<=interval.
//   WAIT: stop=1 -> IDLE. timer==0 & count>0 -> LOAD. timer==0 & count==0 -> IDLE.
//     Else timer<=timer-1.
//  Latency: start asserted in IDLE with data at edge N -> load=1 during cycle N+1.
//  Spacing: consecutive load pulses are interval+2 cycles apart (interval=0 -> every 2nd cycle).
//  A value pushed during WAIT is consumed at that WAIT's expiry, never lost.
//  load_in holds last popped value until next LOAD; never changes outside LOAD entry.
//  stop during LOAD: pulse completes, value is consumed, next state IDLE.
//  FIFO retains remaining entries across stop; start resumes from head.
//  start with empty FIFO: stays IDLE, en=0.
//  Push when full ignored (in_ready=0); no overwrite.
// TESTING
//  Push 0x10,0x20,0x30; interval=3; start=1.
//    -> load pulses with load_in 0x10,0x20,0x30 spaced 5 cycles; then IDLE, en=0.
//  interval=0, 4 entries.
//    -> loads every 2nd cycle; fifo_count 4,3,2,1,0; en high throughout, low after last WAIT.
//  Fill DEPTH entries with start=0.
//    -> in_ready=0, 5th push ignored; start -> first load_in = first pushed value.
//  stop asserted in WAIT after 2nd of 4 loads.
//    -> IDLE next cycle, fifo_count=2; start again -> load_in 3rd value.
//  rst pulse mid-WAIT with 3 queued.
//    -> immediately load=0, en=0, fifo_count=0, in_ready=1, load_in=0.
//  Push during WAIT with FIFO empty (interval=5).
//    -> at expiry enters LOAD with the new value, not IDLE.

Source files
------------

// File: rtl/counter_load_seq.sv
`default_nettype none
// ============================================================================
// Module      : counter_load_seq
// Description : Preload sequencer for the 8-bit loadable counter. Queues
//               values in a small FIFO and issues them as spaced load pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_load_seq #(
    parameter int DEPTH = 4,
    parameter int IW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    input  logic                   start,
    input  logic                   stop,
    input  logic [IW-1:0]          interval,
    output logic                   load,
    output logic [7:0]             load_in,
    output logic                   en,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [IW-1:0]   r_timer;
    logic [7:0]      r_load_in;
    logic            w_ready;
    logic            w_push;
    logic            w_pop;
    logic            w_has_data;
    logic            w_timer_zero;

    assign w_ready      = (r_count < c_DEPTH);
    assign w_push       = in_valid && w_ready;
    assign w_has_data   = (r_count != '0);
    assign w_timer_zero = (r_timer == '0);
    // The head is popped on the same edge that enters LOAD.
    assign w_pop        = (w_state_next == S_LOAD);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!stop && start && w_has_data)
                    w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_state_next = stop ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (stop)
                    w_state_next = S_IDLE;
                else if (w_timer_zero)
                    w_state_next = w_has_data ? S_LOAD : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_timer   <= '0;
            r_load_in <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_load_in <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Interval is captured on the LOAD->WAIT edge, then counts down to zero.
            if (r_state == S_LOAD)
                r_timer <= interval;
            else if (r_state == S_WAIT && !w_timer_zero)
                r_timer <= r_timer - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= in_data;
    end

    assign in_ready   = w_ready;
    assign load       = (r_state == S_LOAD);
    assign load_in    = r_load_in;
    assign en         = (r_state != S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_counter_load_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_load_seq
// Description : Directed vector bench for counter_load_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_load_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       start;
    logic       stop;
    logic [7:0] interval;
    logic       load;
    logic [7:0] load_in;
    logic       en;
    logic       busy;
    logic [2:0] fifo_count;

    int n_cmp;
    int n_bad;

    counter_load_seq #(.DEPTH(4), .IW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .start      (start),
        .stop       (stop),
        .interval   (interval),
        .load       (load),
        .load_in    (load_in),
        .en         (en),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       st;
        logic       sp;
        logic [7:0] iv;
        logic       ld;
        logic [7:0] li;
        logic       en;
        logic [2:0] cnt;
        logic       rdy;
    } vec_t;

    vec_t vq[$];
    int   vec_no;

    task automatic add(input logic v, input logic [7:0] d, input logic st, input logic sp,
                       input logic [7:0] iv, input logic ld, input logic [7:0] li,
                       input logic e, input logic [2:0] cnt, input logic rdy);
        vec_t x;
        x.v = v; x.d = d; x.st = st; x.sp = sp; x.iv = iv;
        x.ld = ld; x.li = li; x.en = e; x.cnt = cnt; x.rdy = rdy;
        vq.push_back(x);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", nm, vec_no, act, exp);
        end
    endtask

    task automatic chk_all(input logic ld, input logic [7:0] li, input logic e,
                           input logic [2:0] cnt, input logic rdy);
        chk("load", int'(load), int'(ld));
        chk("load_in", int'(load_in), int'(li));
        chk("en", int'(en), int'(e));
        chk("busy", int'(busy), int'(e));
        chk("fifo_count", int'(fifo_count), int'(cnt));
        chk("in_ready", int'(in_ready), int'(rdy));
    endtask

    // Inputs change 1 ns after a rising edge; each vector's expectations hold after the next edge.
    task automatic run_table();
        foreach (vq[i]) begin
            in_valid = vq[i].v;
            in_data  = vq[i].d;
            start    = vq[i].st;
            stop     = vq[i].sp;
            interval = vq[i].iv;
            @(posedge clk);
            #1;
            chk_all(vq[i].ld, vq[i].li, vq[i].en, vq[i].cnt, vq[i].rdy);
            vec_no++;
        end
        vq.delete();
        in_valid = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0; n_bad = 0; vec_no = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        start = 1'b0; stop = 1'b0; interval = '0;
        #2;
        chk_all(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Three values, interval 3: loads 5 cycles apart, then IDLE.
        add(1, 8'h10, 0, 0, 3, 0, 8'h00, 0, 1, 1);
        add(1, 8'h20, 0, 0, 3, 0, 8'h00, 0, 2, 1);
        add(1, 8'h30, 0, 0, 3, 0, 8'h00, 0, 3, 1);
        add(0, 8'h00, 1, 0, 3, 1, 8'h10, 1, 2, 1);
        for (int k = 0; k < 4; k++) add(0, 8'h00, 0, 0, 3, 0, 8'h10, 1, 2, 1);
        add(0, 8'h00, 0, 0, 3, 1, 8'h20, 1, 1, 1);
        for (int k = 0; k < 4; k++) add(0, 8'h00, 0, 0, 3, 0, 8'h20, 1, 1, 1);
        add(0, 8'h00, 0, 0, 3, 1, 8'h30, 1, 0, 1);
        for (int k = 0; k < 4; k++) add(0, 8'h00, 0, 0, 3, 0, 8'h30, 1, 0, 1);
        add(0, 8'h00, 0, 0, 3, 0, 8'h30, 0, 0, 1);

        // Fill to DEPTH, fifth push dropped, then interval 0 drains every 2nd cycle.
        add(1, 8'hA1, 0, 0, 0, 0, 8'h30, 0, 1, 1);
        add(1, 8'hB2, 0, 0, 0, 0, 8'h30, 0, 2, 1);
        add(1, 8'hC3, 0, 0, 0, 0, 8'h30, 0, 3, 1);
        add(1, 8'hD4, 0, 0, 0, 0, 8'h30, 0, 4, 0);
        add(1, 8'hEE, 0, 0, 0, 0, 8'h30, 0, 4, 0);
        add(0, 8'h00, 1, 0, 0, 1, 8'hA1, 1, 3, 1);
        add(0, 8'h00, 0, 0, 0, 0, 8'hA1, 1, 3, 1);
        add(0, 8'h00, 0, 0, 0, 1, 8'hB2, 1, 2, 1);
        add(0, 8'h00, 0, 0, 0, 0, 8'hB2, 1, 2, 1);
        add(0, 8'h00, 0, 0, 0, 1, 8'hC3, 1, 1, 1);
        add(0, 8'h00, 0, 0, 0, 0, 8'hC3, 1, 1, 1);
        add(0, 8'h00, 0, 0, 0, 1, 8'hD4, 1, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 8'hD4, 1, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 8'hD4, 0, 0, 1);

        // Stop in WAIT after 2nd load, resume, stop during LOAD, stop beats start.
        add(1, 8'h11, 0, 0, 1, 0, 8'hD4, 0, 1, 1);
        add(1, 8'h22, 0, 0, 1, 0, 8'hD4, 0, 2, 1);
        add(1, 8'h33, 0, 0, 1, 0, 8'hD4, 0, 3, 1);
        add(1, 8'h44, 0, 0, 1, 0, 8'hD4, 0, 4, 0);
        add(0, 8'h00, 1, 0, 1, 1, 8'h11, 1, 3, 1);
        add(0, 8'h00, 0, 0, 1, 0, 8'h11, 1, 3, 1);
        add(0, 8'h00, 0, 0, 1, 0, 8'h11, 1, 3, 1);
        add(0, 8'h00, 0, 0, 1, 1, 8'h22, 1, 2, 1);
        add(0, 8'h00, 0, 0, 1, 0, 8'h22, 1, 2, 1);
        add(0, 8'h00, 0, 1, 1, 0, 8'h22, 0, 2, 1);
        add(0, 8'h00, 1, 0, 1, 1, 8'h33, 1, 1, 1);
        add(0, 8'h00, 0, 1, 1, 0, 8'h33, 0, 1, 1);
        add(0, 8'h00, 1, 1, 1, 0, 8'h33, 0, 1, 1);
        add(1, 8'h55, 0, 0, 5, 0, 8'h33, 0, 2, 1);
        add(1, 8'h66, 0, 0, 5, 0, 8'h33, 0, 3, 1);
        add(1, 8'h77, 0, 0, 5, 0, 8'h33, 0, 4, 0);
        add(0, 8'h00, 1, 0, 5, 1, 8'h44, 1, 3, 1);
        add(0, 8'h00, 0, 0, 5, 0, 8'h44, 1, 3, 1);
        run_table();

        // Asynchronous reset mid-WAIT with three entries queued.
        #3;
        rst = 1'b1;
        #1;
        chk_all(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_all(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);

        // Start with empty FIFO stays IDLE; push during WAIT on empty FIFO is loaded at expiry.
        add(0, 8'h00, 1, 0, 5, 0, 8'h00, 0, 0, 1);
        add(0, 8'h00, 1, 0, 5, 0, 8'h00, 0, 0, 1);
        add(1, 8'h9A, 0, 0, 5, 0, 8'h00, 0, 1, 1);
        add(0, 8'h00, 1, 0, 5, 1, 8'h9A, 1, 0, 1);
        add(1, 8'hBC, 0, 0, 5, 0, 8'h9A, 1, 1, 1);
        for (int k = 0; k < 5; k++) add(0, 8'h00, 0, 0, 5, 0, 8'h9A, 1, 1, 1);
        add(1, 8'hDE, 0, 0, 5, 1, 8'hBC, 1, 1, 1);
        add(0, 8'h00, 0, 0, 5, 0, 8'hBC, 1, 1, 1);
        add(0, 8'h00, 0, 1, 5, 0, 8'hBC, 0, 1, 1);
        add(0, 8'h00, 1, 0, 0, 1, 8'hDE, 1, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 8'hDE, 1, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 8'hDE, 0, 0, 1);
        run_table();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
